// File: rtl/bus_arb.sv
// Two-requester refill arbiter: imem/dmem line fills share one external read bus.
// Round-robin on ties, abandon-drain, per-fill timeout, one RELEASE cycle between fills.
module bus_arb #(
  parameter int BLK_LEN = 58,
  parameter int LINE    = 512,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLK_LEN-1:0] i_addr,
  input  logic               i_rd,
  output logic [LINE-1:0]    i_rdata,
  output logic               i_dv,
  input  logic [BLK_LEN-1:0] d_addr,
  input  logic               d_rd,
  output logic [LINE-1:0]    d_rdata,
  output logic               d_dv,
  output logic [BLK_LEN-1:0] m_addr,
  output logic               m_rd,
  input  logic [LINE-1:0]    m_rdata,
  input  logic               m_dv,
  output logic [1:0]         gnt,
  output logic               bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RELEASE} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t             state, state_nx;
  logic [1:0]         owner, owner_nx;
  logic               last_d, last_d_nx;
  logic [7:0]         cnt, cnt_nx;
  logic [BLK_LEN-1:0] addr_q, addr_nx;
  logic               err_q, err_nx;
  logic               own_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= OWN_NONE;
      last_d <= 1'b0;
      cnt    <= 8'd0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      last_d <= last_d_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    last_d_nx = last_d;
    cnt_nx    = cnt;
    addr_nx   = addr_q;
    err_nx    = 1'b0;
    i_dv      = 1'b0;
    d_dv      = 1'b0;
    own_rd    = (owner == OWN_I) ? i_rd : d_rd;

    case (state)
      IDLE: begin
        // last_d low means imem was served last, so a tie goes to dmem
        if (i_rd && (!d_rd || last_d)) begin
          state_nx  = BUSY;
          owner_nx  = OWN_I;
          addr_nx   = i_addr;
          last_d_nx = 1'b0;
          cnt_nx    = 8'd0;
        end else if (d_rd) begin
          state_nx  = BUSY;
          owner_nx  = OWN_D;
          addr_nx   = d_addr;
          last_d_nx = 1'b1;
          cnt_nx    = 8'd0;
        end
      end

      BUSY, DRAIN: begin
        if (m_dv) begin
          if (state == BUSY) begin
            i_dv = (owner == OWN_I);
            d_dv = (owner == OWN_D);
          end
          state_nx = RELEASE;
          owner_nx = OWN_NONE;
        end else begin
          cnt_nx = cnt + 8'd1;
          if (cnt == TO_LAST) begin
            err_nx   = 1'b1;
            state_nx = RELEASE;
            owner_nx = OWN_NONE;
          end else if (state == BUSY && !own_rd) begin
            state_nx = DRAIN;
          end
        end
      end

      RELEASE: state_nx = IDLE;

      default: begin
        state_nx = IDLE;
        owner_nx = OWN_NONE;
      end
    endcase
  end

  assign m_rd    = (state == BUSY) || (state == DRAIN);
  assign gnt     = owner;
  assign m_addr  = addr_q;
  assign bus_err = err_q;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: two instances (default timeout and TIMEOUT=4) share stimulus;
// expectations go into a scoreboard queue when driven and are compared when sampled.
module tb_bus_arb;

  localparam int BL = 16;
  localparam int LW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [BL-1:0] i_addr, d_addr;
  logic          i_rd, d_rd, m_dv;
  logic [LW-1:0] m_rdata;

  logic [LW-1:0] i_rdata, d_rdata, t_i_rdata, t_d_rdata;
  logic          i_dv, d_dv, m_rd, bus_err, t_i_dv, t_d_dv, t_m_rd, t_bus_err;
  logic [BL-1:0] m_addr, t_m_addr;
  logic [1:0]    gnt, t_gnt;

  int checks = 0;
  int errors = 0;

  string         q_tag[$];
  int            q_sel[$];
  logic [63:0]   q_exp[$];

  bus_arb #(.BLK_LEN(BL), .LINE(LW)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rd(i_rd), .i_rdata(i_rdata), .i_dv(i_dv),
    .d_addr(d_addr), .d_rd(d_rd), .d_rdata(d_rdata), .d_dv(d_dv),
    .m_addr(m_addr), .m_rd(m_rd), .m_rdata(m_rdata), .m_dv(m_dv),
    .gnt(gnt), .bus_err(bus_err)
  );

  bus_arb #(.BLK_LEN(BL), .LINE(LW), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rd(i_rd), .i_rdata(t_i_rdata), .i_dv(t_i_dv),
    .d_addr(d_addr), .d_rd(d_rd), .d_rdata(t_d_rdata), .d_dv(t_d_dv),
    .m_addr(t_m_addr), .m_rd(t_m_rd), .m_rdata(m_rdata), .m_dv(m_dv),
    .gnt(t_gnt), .bus_err(t_bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // status word: {bus_err, i_dv, d_dv, m_rd, gnt}
  function automatic logic [63:0] obs(input int sel);
    case (sel)
      0:       return {58'b0, bus_err, i_dv, d_dv, m_rd, gnt};
      1:       return {58'b0, t_bus_err, t_i_dv, t_d_dv, t_m_rd, t_gnt};
      2:       return {48'b0, m_addr};
      3:       return i_rdata;
      default: return d_rdata;
    endcase
  endfunction

  task automatic ex(input int sel, input string tag, input logic [63:0] v);
    q_sel.push_back(sel);
    q_tag.push_back(tag);
    q_exp.push_back(v);
  endtask

  task automatic smp();
    string       t;
    int          s;
    logic [63:0] e, o;
    #1;
    while (q_exp.size() > 0) begin
      t = q_tag.pop_front();
      s = q_sel.pop_front();
      e = q_exp.pop_front();
      o = obs(s);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", t, o, e);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_rd = 0; d_rd = 0; m_dv = 0;
    i_addr = '0; d_addr = '0; m_rdata = '0;
    ex(0, "rst_status", 6'b000000);
    ex(1, "rst_status_to", 6'b000000);
    ex(2, "rst_addr", 16'h0);
    smp();
    cyc();
    rst = 1'b0;
  endtask

  logic [LW-1:0] line_v;

  initial begin
    // single imem fill, address stability, m_dv ignored in IDLE
    do_reset();
    cyc(); i_rd = 1; i_addr = 16'h123; ex(0, "t1_c0_idle", 6'b000000); smp();
    cyc(); ex(0, "t1_c1_grant", 6'b000101); ex(2, "t1_c1_addr", 16'h123); smp();
    cyc(); i_addr = 16'h456; ex(0, "t1_c2_busy", 6'b000101); ex(2, "t1_c2_addr_hold", 16'h123); smp();
    cyc(); ex(2, "t1_c3_addr_hold", 16'h123); smp();
    cyc(); ex(0, "t1_c4_busy", 6'b000101); smp();
    cyc(); m_dv = 1; line_v = 64'hDEAD_BEEF_0123_4567; m_rdata = line_v;
    ex(0, "t1_c5_idv", 6'b010101); ex(3, "t1_c5_irdata", line_v);
    ex(4, "t1_c5_drdata", line_v); ex(2, "t1_c5_addr", 16'h123); smp();
    cyc(); m_dv = 0; i_rd = 0; ex(0, "t1_c6_release", 6'b000000); smp();
    cyc(); m_dv = 1; ex(0, "t1_c7_idle_mdv_ignored", 6'b000000); smp();
    cyc(); m_dv = 0; ex(0, "t1_c8_idle", 6'b000000); smp();

    // tie after reset goes to dmem, then imem after RELEASE+IDLE
    do_reset();
    cyc(); i_rd = 1; d_rd = 1; i_addr = 16'h0AA; d_addr = 16'h0BB; ex(0, "t2_c0_idle", 6'b000000); smp();
    cyc(); ex(0, "t2_c1_gnt_d", 6'b000110); ex(2, "t2_c1_addr_d", 16'h0BB); smp();
    cyc(); m_dv = 1; ex(0, "t2_c2_ddv", 6'b001110); smp();
    cyc(); m_dv = 0; d_rd = 0; ex(0, "t2_c3_release", 6'b000000); smp();
    cyc(); ex(0, "t2_c4_idle", 6'b000000); smp();
    cyc(); ex(0, "t2_c5_gnt_i", 6'b000101); ex(2, "t2_c5_addr_i", 16'h0AA); smp();
    cyc(); m_dv = 1; ex(0, "t2_c6_idv", 6'b010101); smp();
    cyc(); m_dv = 0; i_rd = 0; ex(0, "t2_c7_release", 6'b000000); smp();
    cyc(); i_rd = 1; d_rd = 1; ex(0, "t2_c8_idle", 6'b000000); smp();
    cyc(); ex(0, "t2_c9_rr_gnt_d", 6'b000110); smp();

    // abandoned dmem fill drains without forwarding dv
    do_reset();
    cyc(); d_rd = 1; d_addr = 16'h321; ex(0, "t3_c0_idle", 6'b000000); smp();
    cyc(); ex(0, "t3_c1_gnt_d", 6'b000110); ex(2, "t3_c1_addr", 16'h321); smp();
    cyc(); ex(0, "t3_c2_busy", 6'b000110); smp();
    cyc(); d_rd = 0; ex(0, "t3_c3_busy_drop", 6'b000110); smp();
    cyc(); ex(0, "t3_c4_drain", 6'b000110); smp();
    cyc(); ex(0, "t3_c5_drain", 6'b000110); smp();
    cyc(); ex(0, "t3_c6_drain", 6'b000110); smp();
    cyc(); m_dv = 1; ex(0, "t3_c7_drain_nodv", 6'b000110); smp();
    cyc(); m_dv = 0; ex(0, "t3_c8_release", 6'b000000); smp();
    cyc(); ex(0, "t3_c9_idle", 6'b000000); smp();

    // timeout on the TIMEOUT=4 instance, then m_dv on the limit cycle wins
    do_reset();
    cyc(); i_rd = 1; i_addr = 16'h077; ex(1, "t4_c0_idle", 6'b000000); smp();
    cyc(); ex(1, "t4_c1_gnt", 6'b000101); smp();
    cyc();
    cyc();
    cyc(); ex(1, "t4_c4_busy_last", 6'b000101); smp();
    cyc(); ex(1, "t4_c5_bus_err", 6'b100000); ex(0, "t4_c5_long_to_busy", 6'b000101); smp();
    cyc(); i_rd = 0; ex(1, "t4_c6_err_gone", 6'b000000); smp();
    cyc(); i_rd = 1; ex(1, "t4_c7_idle", 6'b000000); smp();
    cyc(); ex(1, "t4_c8_gnt", 6'b000101); smp();
    cyc();
    cyc();
    cyc(); m_dv = 1; ex(1, "t4_c11_dv_wins", 6'b010101); smp();
    cyc(); m_dv = 0; i_rd = 0; ex(1, "t4_c12_no_err", 6'b000000); smp();

    // reset mid-fill, stale m_dv ignored
    do_reset();
    cyc(); i_rd = 1; i_addr = 16'h0C3; ex(0, "t5_c0_idle", 6'b000000); smp();
    cyc(); ex(0, "t5_c1_gnt", 6'b000101); smp();
    cyc(); ex(0, "t5_c2_busy", 6'b000101); smp();
    rst = 1; i_rd = 0;
    ex(0, "t5_async_rst", 6'b000000); ex(2, "t5_async_rst_addr", 16'h0); smp();
    rst = 0;
    cyc(); m_dv = 1; ex(0, "t5_c3_stale_mdv", 6'b000000); smp();
    cyc(); m_dv = 0; ex(0, "t5_c4_idle", 6'b000000); smp();

    checks++;
    assert (q_exp.size() == 0) else begin
      errors++;
      $error("FAIL sb_drained observed %0d expected 0", q_exp.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
